// File: rtl/corelet_pkg.sv
// corelet_pkg: shared corelet types and lane arithmetic
// State encoding for the SFP stages and a width-generic saturating add.
package corelet_pkg;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

    // Operands arrive sign-extended to 32 bits; the result is clamped to a signed w-bit range.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [32:0] s, hi, lo;
        s  = 33'(a) + 33'(b);
        hi = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (w - 1));
        return s > hi ? hi[31:0] : (s < lo ? lo[31:0] : s[31:0]);
    endfunction

endpackage

// File: rtl/sfp_lane.sv
// sfp_lane: one lane of saturating accumulate and ReLU
module sfp_lane import corelet_pkg::*; #(
    parameter int psum_bw = 16
) (
    input  logic signed [psum_bw-1:0] acc,
    input  logic signed [psum_bw-1:0] add,
    input  logic                      relu,
    output logic signed [psum_bw-1:0] sum,
    output logic signed [psum_bw-1:0] result
);

    always_comb begin
        sum    = psum_bw'(sat_add(32'(acc), 32'(add), psum_bw));
        result = relu && acc[psum_bw-1] ? '0 : acc;
    end

endmodule

// File: rtl/sfp_acc.sv
// sfp_acc: accumulates kij passes of nij psum vectors, then drains them with optional ReLU
module sfp_acc import corelet_pkg::*; #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int nij     = 16,
    parameter int kij     = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     relu_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [psum_bw*col-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [psum_bw*col-1:0]   out_data,
    output logic [$clog2(nij)-1:0]   out_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int NW = $clog2(nij);
    localparam int KW = kij > 1 ? $clog2(kij) : 1;

    state_t                 state;
    logic [NW-1:0]          nij_cnt;
    logic [KW-1:0]          kij_cnt;
    logic                   relu_q;
    logic [psum_bw*col-1:0] acc_buf [nij];
    logic [psum_bw*col-1:0] cur, sum, relu_out;
    logic                   in_fire, out_fire, last_n, last_k;

    assign cur       = acc_buf[nij_cnt];
    assign in_ready  = state == ACC;
    assign out_valid = state == DRAIN;
    assign busy      = state != IDLE;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign last_n    = nij_cnt == NW'(nij - 1);
    assign last_k    = kij_cnt == KW'(kij - 1);
    assign out_data  = out_valid ? relu_out : '0;
    assign out_idx   = out_valid ? nij_cnt : '0;

    for (genvar l = 0; l < col; l++) begin : g_lane
        sfp_lane #(.psum_bw(psum_bw)) u_lane (
            .acc   (cur[l*psum_bw +: psum_bw]),
            .add   (in_data[l*psum_bw +: psum_bw]),
            .relu  (relu_q),
            .sum   (sum[l*psum_bw +: psum_bw]),
            .result(relu_out[l*psum_bw +: psum_bw])
        );
    end

    // The first pass overwrites, so the buffer never needs a clear cycle.
    always_ff @(posedge clk)
        if (in_fire) acc_buf[nij_cnt] <= kij_cnt == '0 ? in_data : sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            nij_cnt <= '0;
            kij_cnt <= '0;
            relu_q  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state   <= ACC;
                    relu_q  <= relu_en;
                    nij_cnt <= '0;
                    kij_cnt <= '0;
                end
                ACC: if (in_fire) begin
                    nij_cnt <= last_n ? '0 : nij_cnt + 1'b1;
                    if (last_n) begin
                        kij_cnt <= last_k ? '0 : kij_cnt + 1'b1;
                        if (last_k) state <= DRAIN;
                    end
                end
                DRAIN: if (out_fire) begin
                    nij_cnt <= last_n ? '0 : nij_cnt + 1'b1;
                    if (last_n) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfp_acc.sv
// tb_sfp_acc: directed checks of sfp_acc with a kij=2 and a kij=1 instance (nij=4)
module tb_sfp_acc;

    logic         clk = 1'b0;
    logic         reset;
    logic         start [2];
    logic         relu_en [2];
    logic         in_valid [2];
    logic         in_ready [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic         busy [2];
    logic         done [2];
    logic [127:0] in_data [2];
    logic [127:0] out_data [2];
    logic [1:0]   out_idx [2];
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    sfp_acc #(.col(8), .psum_bw(16), .nij(4), .kij(2)) u0 (
        .clk(clk), .reset(reset), .start(start[0]), .relu_en(relu_en[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_idx(out_idx[0]), .busy(busy[0]), .done(done[0])
    );

    sfp_acc #(.col(8), .psum_bw(16), .nij(4), .kij(1)) u1 (
        .clk(clk), .reset(reset), .start(start[1]), .relu_en(relu_en[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_idx(out_idx[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rep(input int v);
        logic [127:0] r;
        for (int l = 0; l < 8; l++) r[l*16 +: 16] = 16'(v);
        return r;
    endfunction

    function automatic logic [127:0] lanes(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    function automatic int sat(input int v);
        return v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
    endfunction

    // Called at a negedge; returns at the negedge after the transfer, in_valid left high.
    task automatic push(input int u, input logic [127:0] v);
        int n = 0;
        in_valid[u] = 1'b1;
        in_data[u]  = v;
        while (!in_ready[u] && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("push_timeout", 128'(in_ready[u]), 128'(1));
        @(negedge clk);
    endtask

    task automatic pop(input int u, input logic [127:0] e, input int idx, input string tag);
        int n = 0;
        out_ready[u] = 1'b1;
        while (!out_valid[u] && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check({tag, "_timeout"}, 128'(out_valid[u]), 128'(1));
        check({tag, "_data"}, out_data[u], e);
        check({tag, "_idx"}, 128'(out_idx[u]), 128'(idx));
        @(negedge clk);
    endtask

    task automatic start_tile(input int u, input logic r);
        start[u]   = 1'b1;
        relu_en[u] = r;
        @(negedge clk);
        start[u] = 1'b0;
        check("start_busy", 128'(busy[u]), 128'(1));
    endtask

    initial begin : main
        int m [4][8];
        logic [127:0] v, e0;
        for (int u = 0; u < 2; u++) begin
            start[u] = 0; relu_en[u] = 0; in_valid[u] = 0; out_ready[u] = 0; in_data[u] = '0;
        end
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 128'(busy[0]), 0);
        check("rst_in_ready", 128'(in_ready[0]), 0);
        check("rst_out_valid", 128'(out_valid[0]), 0);
        check("rst_done", 128'(done[0]), 0);
        check("rst_out_data", out_data[0], 0);
        check("rst_out_idx", 128'(out_idx[0]), 0);
        reset = 1'b1;
        @(negedge clk);

        // in_valid while IDLE must not be accepted
        in_valid[0] = 1'b1;
        in_data[0]  = rep(99);
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", 128'(in_ready[0]), 0);
        end
        check("idle_busy", 128'(busy[0]), 0);
        in_valid[0] = 1'b0;

        // basic accumulate: 1 + 1 per lane
        start_tile(0, 1'b0);
        for (int k = 0; k < 2; k++) for (int n = 0; n < 4; n++) push(0, rep(1));
        in_valid[0] = 1'b0;
        check("latency_out_valid", 128'(out_valid[0]), 1);
        check("drain_in_ready", 128'(in_ready[0]), 0);
        for (int n = 0; n < 4; n++) pop(0, rep(2), n, "basic");
        out_ready[0] = 1'b0;
        check("done_pulse", 128'(done[0]), 1);
        check("idle_after_drain", 128'(busy[0]), 0);
        @(negedge clk);
        check("done_cleared", 128'(done[0]), 0);

        // saturation at both rails
        start_tile(0, 1'b0);
        for (int n = 0; n < 4; n++) push(0, lanes(32767, -32768, 100, 100, 100, 100, 100, 100));
        for (int n = 0; n < 4; n++) push(0, lanes(1, -1, -300, -300, -300, -300, -300, -300));
        in_valid[0] = 1'b0;
        for (int n = 0; n < 4; n++)
            pop(0, lanes(32767, -32768, -200, -200, -200, -200, -200, -200), n, "sat");
        out_ready[0] = 1'b0;

        // ReLU latched at start; toggling relu_en mid-tile has no effect
        start_tile(1, 1'b1);
        relu_en[1] = 1'b0;
        for (int n = 0; n < 4; n++) push(1, lanes(-5, 0, 7, -1, 2, -32768, 32767, -100));
        in_valid[1] = 1'b0;
        for (int n = 0; n < 4; n++) pop(1, lanes(0, 0, 7, 0, 2, 0, 32767, 0), n, "relu_on");
        out_ready[1] = 1'b0;
        start_tile(1, 1'b0);
        relu_en[1] = 1'b1;
        for (int n = 0; n < 4; n++) push(1, lanes(-5, 0, 7, -1, 2, -32768, 32767, -100));
        in_valid[1] = 1'b0;
        for (int n = 0; n < 4; n++)
            pop(1, lanes(-5, 0, 7, -1, 2, -32768, 32767, -100), n, "relu_off");
        out_ready[1] = 1'b0;

        // backpressure both sides, distinct data per vector, start pulsed mid-ACC
        start_tile(0, 1'b0);
        for (int k = 0; k < 2; k++)
            for (int n = 0; n < 4; n++) begin
                for (int l = 0; l < 8; l++) begin
                    v[l*16 +: 16] = 16'(k * 1000 + n * 10 + l - 20);
                    m[n][l] = k == 0 ? k * 1000 + n * 10 + l - 20 : sat(m[n][l] + k * 1000 + n * 10 + l - 20);
                end
                in_valid[0] = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if (k == 1 && n == 0) start[0] = 1'b1;
                push(0, v);
                start[0] = 1'b0;
            end
        in_valid[0] = 1'b0;
        for (int l = 0; l < 8; l++) e0[l*16 +: 16] = 16'(m[0][l]);
        for (int c = 0; c < 3; c++) begin
            start[0]    = c == 1;
            in_valid[0] = c == 1;
            @(negedge clk);
            check("stall_data", out_data[0], e0);
            check("stall_idx", 128'(out_idx[0]), 0);
            check("stall_in_ready", 128'(in_ready[0]), 0);
        end
        start[0]    = 1'b0;
        in_valid[0] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            for (int l = 0; l < 8; l++) v[l*16 +: 16] = 16'(m[n][l]);
            out_ready[0] = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            pop(0, v, n, "bp");
        end
        out_ready[0] = 1'b0;
        check("bp_done", 128'(done[0]), 1);

        // reset mid-ACC at kij_cnt=1, then a clean tile
        start_tile(0, 1'b0);
        for (int n = 0; n < 5; n++) push(0, rep(50));
        in_valid[0] = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", 128'(busy[0]), 0);
        check("mid_rst_in_ready", 128'(in_ready[0]), 0);
        check("mid_rst_done", 128'(done[0]), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_done", 128'(done[0]), 0);
        start_tile(0, 1'b0);
        for (int k = 0; k < 2; k++) for (int n = 0; n < 4; n++) push(0, rep(3));
        in_valid[0] = 1'b0;
        for (int n = 0; n < 4; n++) pop(0, rep(6), n, "after_rst");
        out_ready[0] = 1'b0;
        check("after_rst_done", 128'(done[0]), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
